note_sequencer: RTL

Memory-mapped note sequencer that feeds the square-wave audio unit. Software queues notes (half-period plus duration) into a FIFO. The block then writes each half-period into the audio unit's write port for the note's duration and silences it when the queue drains. It sits on the peripheral bus beside the audio unit and is the only writer of that unit's control register.

---
 rtl/note_sequencer.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : note_sequencer
//  Description : Memory-mapped note sequencer for the square-wave audio unit.
//                Software pushes {dur, half-period} words into a FIFO. Each
//                note's half-period is written to the audio unit, held for
//                dur ticks of TICK_DIV clocks, and the unit is silenced when
//                the queue drains or playback is aborted.
//  Ports       : clk, rst_n (async, active-low)
//                addr/wdata/wenable : peripheral bus write port
//                rdata              : combinational read data (NOTE/CTRL/REMAIN)
//                aud_wdata/aud_wenable : registered write port to audio unit
//                irq                : queue-drained interrupt (NOTE_SEQ_IRQ_EN)
//  Options     : `define NOTE_SEQ_IRQ_EN to build the irq port and irq_en bit.
//  Revision    : 1.0  initial release
// ============================================================================
module note_sequencer #(
    parameter int DEPTH    = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic        wenable,
    output logic [31:0] rdata,
    output logic [31:0] aud_wdata,
    output logic        aud_wenable
`ifdef NOTE_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(TICK_DIV);

    localparam logic [AW:0]   c_DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE   = AW'(1);
    localparam logic [PW-1:0] c_PRE_ONE   = PW'(1);
    localparam logic [PW-1:0] c_TICK_LAST = PW'(TICK_DIV - 1);
    // PLAY is one cycle shorter than dur*TICK_DIV because the LOAD cycle
    // completes the period, so the last PLAY cycle is one before the wrap.
    localparam logic [PW-1:0] c_TICK_PEN  = PW'(TICK_DIV - 2);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_PLAY    = 2'd2,
        S_SILENCE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [AW:0]    count_q, count_d;
    logic           en_q;
    logic           ovf_q;
    logic [11:0]    remain_q, remain_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [31:0]    aud_wdata_q, aud_wdata_d;
    logic           aud_wenable_q, aud_wenable_d;

    logic           w_note_wr, w_ctrl_wr, w_flush, w_en_clr, w_abort;
    logic           w_empty, w_full, w_pop, w_push;
    logic           w_tick_wrap, w_note_end, w_irq_en;
    logic [31:0]    w_head;
    logic [11:0]    w_head_dur;

    assign w_note_wr   = wenable && (addr == 2'd0);
    assign w_ctrl_wr   = wenable && (addr == 2'd1);
    assign w_flush     = w_ctrl_wr && wdata[1];
    assign w_en_clr    = w_ctrl_wr && !wdata[0];
    assign w_abort     = w_flush || w_en_clr;
    assign w_empty     = (count_q == '0);
    assign w_full      = (count_q == c_DEPTH_CNT);
    // A pop frees a slot in the same cycle, so a push while full still lands.
    assign w_push      = w_note_wr && (!w_full || w_pop);
    assign w_head      = mem_q[rd_ptr_q];
    assign w_head_dur  = w_head[31:20];
    assign w_tick_wrap = (presc_q == c_TICK_LAST);
    assign w_note_end  = (remain_q == 12'd1) && (presc_q == c_TICK_PEN);

    // ------------------------------------------------------------------
    // Sequencer FSM: next state, timers and audio write
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        remain_d      = remain_q;
        presc_d       = presc_q;
        aud_wdata_d   = aud_wdata_q;
        aud_wenable_d = 1'b0;
        w_pop         = 1'b0;
        case (state_q)
            S_IDLE: begin
                remain_d = 12'd0;
                presc_d  = '0;
                // A CTRL write landing in this cycle (disable or flush)
                // must not start a note with stale enable state.
                if (en_q && !w_empty && !w_abort) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                w_pop         = !w_empty;
                aud_wdata_d   = {12'd0, w_head[19:0]};
                aud_wenable_d = 1'b1;
                remain_d      = (w_head_dur == 12'd0) ? 12'd1 : w_head_dur;
                presc_d       = '0;
                state_d       = S_PLAY;
                if (w_abort) begin
                    remain_d = 12'd0;
                    state_d  = S_SILENCE;
                end
            end
            S_PLAY: begin
                if (w_abort) begin
                    remain_d = 12'd0;
                    presc_d  = '0;
                    state_d  = S_SILENCE;
                end else if (w_note_end) begin
                    remain_d = 12'd0;
                    presc_d  = '0;
                    state_d  = (en_q && !w_empty) ? S_LOAD : S_SILENCE;
                end else if (w_tick_wrap) begin
                    presc_d  = '0;
                    remain_d = remain_q - 12'd1;
                end else begin
                    presc_d  = presc_q + c_PRE_ONE;
                end
            end
            S_SILENCE: begin
                remain_d      = 12'd0;
                presc_d       = '0;
                aud_wdata_d   = 32'd0;
                aud_wenable_d = 1'b1;
                state_d       = w_flush ? S_SILENCE : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            remain_q      <= 12'd0;
            presc_q       <= '0;
            aud_wdata_q   <= 32'd0;
            aud_wenable_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            remain_q      <= remain_d;
            presc_q       <= presc_d;
            aud_wdata_q   <= aud_wdata_d;
            aud_wenable_q <= aud_wenable_d;
        end
    end

    // ------------------------------------------------------------------
    // Note FIFO
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            count_d = count_q - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else if (w_flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
            end
            count_q <= count_d;
            if (w_note_wr && !w_push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Control register and optional interrupt
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q <= 1'b0;
        end else if (w_ctrl_wr) begin
            en_q <= wdata[0];
        end
    end

`ifdef NOTE_SEQ_IRQ_EN
    logic irq_en_q;
    logic irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                irq_en_q <= wdata[2];
            end
            irq_q <= irq_en_q && (state_q == S_IDLE) && w_empty;
        end
    end

    assign w_irq_en = irq_en_q;
    assign irq      = irq_q;
`else
    assign w_irq_en = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read mux and outputs
    // ------------------------------------------------------------------
    always_comb begin
        rdata = 32'd0;
        case (addr)
            2'd1: begin
                rdata[0]    = en_q;
                rdata[1]    = (state_q != S_IDLE);
                rdata[2]    = w_empty;
                rdata[3]    = w_full;
                rdata[4]    = ovf_q;
                rdata[5]    = w_irq_en;
                rdata[15:8] = 8'(count_q);
            end
            2'd2: begin
                rdata[11:0] = remain_q;
            end
            default: begin
                rdata = 32'd0;
            end
        endcase
    end

    assign aud_wdata   = aud_wdata_q;
    assign aud_wenable = aud_wenable_q;

endmodule
`default_nettype wire
